// File: rtl/echo_pkg.sv
// Shared types and helpers for the stereo echo stage.
package echo_pkg;

  localparam int WIDTH_DEF      = 16;
  localparam int DEPTH_LOG2_DEF = 10;

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_IDLE  = 3'd1,
    S_READ  = 3'd2,
    S_CALC  = 3'd3,
    S_WRITE = 3'd4
  } echo_state_t;

  // Add a sample and its echo term in wide integer arithmetic, then clamp
  // to the signed range of a w-bit sample. Valid for w up to 30.
  function automatic int sat_add(input int in, input int echo, input int w = WIDTH_DEF);
    int s;
    int hi;
    int lo;
    s  = in + echo;
    hi = (1 <<< (w - 1)) - 1;
    lo = -hi - 1;
    if (s > hi)      return hi;
    else if (s < lo) return lo;
    else             return s;
  endfunction

endpackage

// File: rtl/i2s_echo_if.sv
// Sample stream between receiver, echo stage and transmitter.
interface i2s_echo_if
  import echo_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic [WIDTH-1:0] left_in;
  logic [WIDTH-1:0] right_in;
  logic             pktI2SRxChanged_i;
  logic [WIDTH-1:0] left_out;
  logic [WIDTH-1:0] right_out;
  logic             pktEchoValid_o;

  // master: the side that supplies received pairs and consumes results
  modport master (
    output left_in, right_in, pktI2SRxChanged_i,
    input  left_out, right_out, pktEchoValid_o
  );

  // slave: the echo stage itself
  modport slave (
    input  left_in, right_in, pktI2SRxChanged_i,
    output left_out, right_out, pktEchoValid_o
  );
endinterface

// File: rtl/echo_ram.sv
// Single-port synchronous RAM holding stereo pairs; registered read output.
module echo_ram #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic          i_re,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_rdata;

  // Write has priority; a read only updates the output register when asked.
  always_ff @(posedge clk) begin
    if (i_we)      r_mem[i_addr] <= i_wdata;
    else if (i_re) r_rdata       <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/i2s_echo.sv
// Stereo echo stage: circular pair buffer with decayed feedback and saturation.
module i2s_echo
  import echo_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  sclk_in,
  input  logic                  rst,
  i2s_echo_if.slave             io,
  input  logic [DEPTH_LOG2-1:0] delay_i,
  input  logic [3:0]            decay_shift_i,
  output logic                  busy_o,
  output logic                  overrun_o
);
  echo_state_t            r_state;
  logic [DEPTH_LOG2-1:0]  r_clr_cnt;
  logic [DEPTH_LOG2-1:0]  r_wr_ptr;
  logic                   r_overrun;
  // [0]: pair written this cycle, [1]: outputs just loaded (valid pulse)
  logic [1:0]             r_vld_pipe;
  logic [WIDTH-1:0]       r_left_out;
  logic [WIDTH-1:0]       r_right_out;

  logic signed [WIDTH-1:0] r_in_l;
  logic signed [WIDTH-1:0] r_in_r;
  logic [DEPTH_LOG2-1:0]   r_delay;
  logic [3:0]              r_shift;
  logic [WIDTH-1:0]        r_sat_l;
  logic [WIDTH-1:0]        r_sat_r;

  logic                    w_stb;
  logic                    w_we;
  logic                    w_re;
  logic [DEPTH_LOG2-1:0]   w_addr;
  logic [2*WIDTH-1:0]      w_wdata;
  logic [2*WIDTH-1:0]      w_rdata;
  logic signed [WIDTH-1:0] w_rd_l;
  logic signed [WIDTH-1:0] w_rd_r;
  logic signed [WIDTH-1:0] w_echo_l;
  logic signed [WIDTH-1:0] w_echo_r;
  logic                    w_mute;
  logic [WIDTH-1:0]        w_sat_l;
  logic [WIDTH-1:0]        w_sat_r;

  assign w_stb = io.pktI2SRxChanged_i;

  // RAM port sharing: clear sweep, echo read, result write never overlap.
  always_comb begin
    w_we    = 1'b0;
    w_re    = 1'b0;
    w_addr  = r_wr_ptr;
    w_wdata = {r_sat_l, r_sat_r};
    case (r_state)
      S_CLEAR: begin
        w_we    = ~rst;
        w_addr  = r_clr_cnt;
        w_wdata = '0;
      end
      S_READ:  begin
        w_re   = 1'b1;
        w_addr = r_wr_ptr - r_delay;
      end
      S_WRITE: w_we = ~rst;
      default: ;
    endcase
  end

  echo_ram #(.DW(2*WIDTH), .AW(DEPTH_LOG2)) u_ram (
    .clk     (sclk_in),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  assign w_rd_l = w_rdata[2*WIDTH-1:WIDTH];
  assign w_rd_r = w_rdata[WIDTH-1:0];
  assign w_mute = (r_delay == '0) || (r_shift == '0);

  // Echo term per channel; kept in if/else so the shift stays arithmetic.
  always_comb begin
    w_echo_l = '0;
    w_echo_r = '0;
    if (!w_mute) begin
      w_echo_l = w_rd_l >>> r_shift;
      w_echo_r = w_rd_r >>> r_shift;
    end
    w_sat_l = WIDTH'(sat_add(32'(r_in_l), 32'(w_echo_l), WIDTH));
    w_sat_r = WIDTH'(sat_add(32'(r_in_r), 32'(w_echo_r), WIDTH));
  end

  // Control: FSM, clear sweep, write pointer, sticky overrun, output regs.
  always_ff @(posedge sclk_in) begin
    if (rst) begin
      r_state     <= S_CLEAR;
      r_clr_cnt   <= '0;
      r_wr_ptr    <= '0;
      r_overrun   <= 1'b0;
      r_vld_pipe  <= '0;
      r_left_out  <= '0;
      r_right_out <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[0], r_state == S_WRITE};
      if (r_vld_pipe[0]) begin
        r_left_out  <= r_sat_l;
        r_right_out <= r_sat_r;
      end
      if (w_stb && (r_state == S_READ || r_state == S_CALC || r_state == S_WRITE))
        r_overrun <= 1'b1;
      case (r_state)
        S_CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == '1) r_state <= S_IDLE;
        end
        S_IDLE:  if (w_stb) r_state <= S_READ;
        S_READ:  r_state <= S_CALC;
        S_CALC:  r_state <= S_WRITE;
        S_WRITE: begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

  // Datapath latches: inputs on accepted strobe, saturated pair in CALC.
  always_ff @(posedge sclk_in) begin
    if (r_state == S_IDLE && w_stb) begin
      r_in_l  <= io.left_in;
      r_in_r  <= io.right_in;
      r_delay <= delay_i;
      r_shift <= decay_shift_i;
    end
    if (r_state == S_CALC) begin
      r_sat_l <= w_sat_l;
      r_sat_r <= w_sat_r;
    end
  end

  assign io.left_out       = r_left_out;
  assign io.right_out      = r_right_out;
  assign io.pktEchoValid_o = r_vld_pipe[1];
  assign busy_o            = (r_state != S_IDLE);
  assign overrun_o         = r_overrun;
endmodule

// File: tb/tb_i2s_echo.sv
// Randomized bench for i2s_echo against an integer-arithmetic echo model.
module tb_i2s_echo;
  import echo_pkg::*;

  localparam int W  = 16;
  localparam int DL = 4;
  localparam int N  = 1 << DL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DL-1:0] dly = '0;
  logic [3:0]    shf = '0;
  logic          busy;
  logic          ovr;

  i2s_echo_if #(.WIDTH(W)) bus ();

  i2s_echo #(.WIDTH(W), .DEPTH_LOG2(DL)) dut (
    .sclk_in       (clk),
    .rst           (rst),
    .io            (bus),
    .delay_i       (dly),
    .decay_shift_i (shf),
    .busy_o        (busy),
    .overrun_o     (ovr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference buffer: what the echo stage should hold, pair by pair
  logic [W-1:0] ml [N];
  logic [W-1:0] mr [N];
  int           wp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] chan(input logic [W-1:0] x, input logic [W-1:0] old,
                                        input int d, input int s);
    int e;
    int v;
    e = 0;
    if (d != 0 && s != 0) begin
      e = int'($signed(old));
      e = e >>> s;
    end
    v = int'($signed(x)) + e;
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return v[W-1:0];
  endfunction

  task automatic model_step(input logic [W-1:0] l, input logic [W-1:0] r, input int d,
                            input int s, output logic [W-1:0] el, output logic [W-1:0] er);
    int ra;
    ra = (wp - d) & (N - 1);
    el = chan(l, ml[ra], d, s);
    er = chan(r, mr[ra], d, s);
    ml[wp] = el;
    mr[wp] = er;
    wp = (wp + 1) % N;
  endtask

  // Called at a falling edge; asserts rst for two cycles, then times the clear.
  task automatic do_reset();
    int n;
    bit seen;
    seen = 0;
    rst = 1'b1;
    bus.pktI2SRxChanged_i = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.pktEchoValid_o) seen = 1;
    end
    chk("rst_left",  bus.left_out, 0);
    chk("rst_right", bus.right_out, 0);
    chk("rst_valid", bus.pktEchoValid_o, 0);
    chk("rst_ovr",   ovr, 0);
    chk("rst_busy",  busy, 1);
    rst = 1'b0;
    n = 0;
    while (busy && n < 4 * N) begin
      n++;
      bus.pktI2SRxChanged_i = (n == 3);
      @(negedge clk);
      if (bus.pktEchoValid_o) seen = 1;
    end
    bus.pktI2SRxChanged_i = 1'b0;
    chk("clear_len", n, N);
    chk("clear_no_valid", seen, 0);
    chk("clear_ovr", ovr, 0);
    for (int i = 0; i < N; i++) begin
      ml[i] = '0;
      mr[i] = '0;
    end
    wp = 0;
  endtask

  // Called at a falling edge; one pair through, latency and result checked.
  task automatic send(input logic [W-1:0] l, input logic [W-1:0] r, input int d, input int s,
                      output logic [W-1:0] ol, output logic [W-1:0] orr);
    int k;
    logic [W-1:0] el;
    logic [W-1:0] er;
    bus.left_in  = l;
    bus.right_in = r;
    dly = DL'(d);
    shf = 4'(s);
    bus.pktI2SRxChanged_i = 1'b1;
    @(negedge clk);
    bus.pktI2SRxChanged_i = 1'b0;
    bus.left_in  = W'($urandom);
    bus.right_in = W'($urandom);
    dly = DL'($urandom);
    shf = 4'($urandom);
    chk("busy_after_accept", busy, 1);
    k = 1;
    while (!bus.pktEchoValid_o && k < 12) begin
      @(negedge clk);
      k++;
    end
    chk("latency", k, 5);
    model_step(l, r, d, s, el, er);
    ol  = bus.left_out;
    orr = bus.right_out;
    chk($sformatf("left d=%0d s=%0d in=%h", d, s, l), ol, el);
    chk($sformatf("right d=%0d s=%0d in=%h", d, s, r), orr, er);
    @(negedge clk);
    chk("valid_one_cycle", bus.pktEchoValid_o, 0);
  endtask

  initial begin
    logic [W-1:0] ol;
    logic [W-1:0] orr;
    logic [W-1:0] l;
    logic [W-1:0] r;
    logic [W-1:0] el;
    logic [W-1:0] er;
    logic [W-1:0] echo_in [4];
    logic [W-1:0] echo_exp [4];
    int d;
    int s;
    int pulses;

    echo_in  = '{16'h4000, 16'h0000, 16'h0000, 16'h0000};
    echo_exp = '{16'h4000, 16'h0000, 16'h2000, 16'h0000};
    bus.left_in = '0;
    bus.right_in = '0;
    bus.pktI2SRxChanged_i = 1'b0;
    wp = 0;

    do_reset();

    // first pair after clear: buffer reads zero
    send(16'h1234, 16'hEDCC, 4, 1, ol, orr);
    chk("first_left", ol, 16'h1234);
    chk("first_right", orr, 16'hEDCC);

    // echo with feedback
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(echo_in[i], echo_in[i], 2, 1, ol, orr);
      chk($sformatf("echo_const_%0d", i), ol, echo_exp[i]);
    end

    // saturation both ways
    send(16'h7000, 16'h7000, 1, 1, ol, orr);
    send(16'h7000, 16'h7000, 1, 1, ol, orr);
    chk("sat_pos", ol, 16'h7FFF);
    send(16'h9000, 16'h9000, 1, 1, ol, orr);
    send(16'h9000, 16'h9000, 1, 1, ol, orr);
    chk("sat_neg", orr, 16'h8000);

    // pointer wrap with a fixed delay
    for (int i = 0; i < 20; i++)
      send(W'($urandom), W'($urandom), 3, $urandom_range(1, 4), ol, orr);

    // bypass
    for (int i = 0; i < 8; i++) begin
      l = W'($urandom);
      r = W'($urandom);
      send(l, r, 0, $urandom_range(0, 15), ol, orr);
      chk("bypass", {ol, orr}, {l, r});
    end

    // muted echo
    for (int i = 0; i < 8; i++) begin
      l = W'($urandom);
      r = W'($urandom);
      send(l, r, $urandom_range(1, N - 1), 0, ol, orr);
      chk("mute", {ol, orr}, {l, r});
    end

    // free random traffic with idle gaps
    for (int i = 0; i < 40; i++) begin
      d = $urandom_range(0, N - 1);
      s = $urandom_range(0, 15);
      send(W'($urandom), W'($urandom), d, s, ol, orr);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    chk("no_overrun_yet", ovr, 0);

    // overrun: second strobe lands two cycles after the first
    bus.left_in = 16'h1111;
    bus.right_in = 16'h2222;
    dly = 2;
    shf = 1;
    bus.pktI2SRxChanged_i = 1'b1;
    @(negedge clk);
    bus.pktI2SRxChanged_i = 1'b0;
    @(negedge clk);
    bus.left_in = 16'h5555;
    bus.right_in = 16'h6666;
    bus.pktI2SRxChanged_i = 1'b1;
    @(negedge clk);
    bus.pktI2SRxChanged_i = 1'b0;
    pulses = 0;
    ol = '0;
    orr = '0;
    for (int i = 0; i < 8; i++) begin
      if (bus.pktEchoValid_o) begin
        pulses++;
        ol = bus.left_out;
        orr = bus.right_out;
      end
      @(negedge clk);
    end
    model_step(16'h1111, 16'h2222, 2, 1, el, er);
    chk("ovr_pulses", pulses, 1);
    chk("ovr_left", ol, el);
    chk("ovr_right", orr, er);
    chk("ovr_held", bus.left_out, el);
    chk("ovr_flag", ovr, 1);

    // dropped pair must not have entered the buffer
    for (int i = 0; i < 4; i++)
      send(W'($urandom), W'($urandom), $urandom_range(1, 3), 1, ol, orr);
    chk("ovr_sticky", ovr, 1);

    // reset while the pair is in CALC
    bus.left_in = 16'h7777;
    bus.right_in = 16'h8888;
    dly = 1;
    shf = 1;
    bus.pktI2SRxChanged_i = 1'b1;
    @(negedge clk);
    bus.pktI2SRxChanged_i = 1'b0;
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 6; i++)
      send(W'($urandom), W'($urandom), $urandom_range(0, N - 1), $urandom_range(1, 3), ol, orr);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/i2s_echo.md
# i2s_echo

Stereo echo/delay stage between the I2S receiver and the I2S transmitter. It consumes each received left/right sample pair on the receiver's packet-changed strobe and adds a decayed copy of the sample written `delay_i` pairs earlier, using a circular buffer with feedback. It registers the resulting pair for the transmitter. All logic runs on the I2S bit clock.

## Interface
- `WIDTH`, 16: sample width per channel, two's complement.
- `DEPTH_LOG2`, 10: log2 of buffer depth in stereo pairs (1024).
- `sclk_in`  in  1  I2S bit clock, sole clock.
- `rst`  in  1  reset, synchronous and active-high.
- `left_in`  in  WIDTH  received left sample; valid when strobe is high.
- `right_in`  in  WIDTH  received right sample; valid when strobe is high.
- `pktI2SRxChanged_i`  in  1  one-cycle strobe marking a new stereo pair.
- `delay_i`  in  DEPTH_LOG2  echo delay in pairs; sampled on the accepted strobe; 0 selects bypass.
- `decay_shift_i`  in  4  feedback attenuation, echo term = delayed >>> shift; 0 mutes the echo.
- `left_out`  out  WIDTH  processed left sample, held between updates.
- `right_out`  out  WIDTH  processed right sample, held between updates.
- `pktEchoValid_o`  out  1  one-cycle pulse when the outputs update.
- `busy_o`  out  1  high while clearing or processing a pair.
- `overrun_o`  out  1  sticky; set when a strobe arrives while processing; cleared only by `rst`.

## Operation
- States: CLEAR, IDLE, READ, CALC, WRITE.
- CLEAR
  - Entered on `rst`.
  - Writes zero to buffer addresses 0 .. 2^DEPTH_LOG2-1, one address per cycle, then goes to IDLE.
  - Strobes in CLEAR are dropped and do not set `overrun_o`.
- IDLE
  - On a strobe: latch `left_in`, `right_in`, `delay_i` and `decay_shift_i`, then go to READ.
- READ
  - Read address = `wr_ptr - delay` modulo 2^DEPTH_LOG2 (natural wrap).
  - Go to CALC.
- CALC (RAM data valid)
  - Per channel: echo = (delay==0 or shift==0) ? 0 : rd_data >>> shift, arithmetic shift.
  - sum = in + echo, computed at WIDTH+1 bits.
  - Saturate sum to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - Go to WRITE.
- WRITE
  - Write the saturated pair {left, right} at `wr_ptr`.
  - Load `left_out`/`right_out` with the saturated pair and pulse `pktEchoValid_o`.
  - `wr_ptr` increments and wraps from 2^DEPTH_LOG2-1 to 0.
  - Return to IDLE.
- Bypass (delay 0): output equals input exactly. The input is still written to the buffer and `wr_ptr` still advances.
- A strobe in READ, CALC or WRITE is dropped and sets `overrun_o`. A strobe coinciding with the WRITE→IDLE transition is also dropped.
- `rst` mid-operation: abandon the current pair, no valid pulse, re-enter CLEAR.

## Timing
- Reset values, applied the cycle after `rst` is sampled high:
  - `left_out`, `right_out`: 0.
  - `pktEchoValid_o`: 0.
  - `overrun_o`: 0.
  - `busy_o`: 1 (CLEAR).
  - `wr_ptr`: 0.
- CLEAR lasts 2^DEPTH_LOG2 cycles after `rst` deasserts. `busy_o` falls in the cycle IDLE is entered.
- Latency: strobe sampled at edge N → `pktEchoValid_o` high and outputs updated after edge N+4.
- Throughput: one pair per 4 cycles minimum. At 64·fs the I2S pair period is ≥32 cycles, so overrun signals a system fault.
- `busy_o` is high from the edge after strobe acceptance until returning to IDLE.
- RAM is single-port with a registered read (1-cycle latency) and a write in WRITE only. No read and write occur in the same cycle.

## Structure
- Package `echo_pkg`:
  - state enum `echo_state_t`;
  - function `sat_add(in, echo)` returning the WIDTH-bit clamp;
  - default WIDTH/DEPTH_LOG2 localparams.
- Sub-module `echo_ram`: single-port synchronous RAM, 2^DEPTH_LOG2 × 2·WIDTH, registered read, no reset on the array.
- `i2s_echo` holds the FSM, pointer, latches, arithmetic and output registers.
- Intended top-level placement: between the I2S receiver's `left_chan`/`right_chan` outputs and the transmitter's inputs, driven by the same strobe.

## Test plan
- Reset and clear: assert `rst` 2 cycles, release → `busy_o` high for exactly 1024 cycles. Then strobe L=0x1234, R=0xEDCC with delay=4, shift=1 → outputs 0x1234/0xEDCC (buffer reads zero).
- Echo: delay=2, shift=1, feed pairs 0x4000, 0, 0, 0 (both channels) → outputs 0x4000, 0x0000, 0x2000, 0x0000. The third output is 0x2000 because the buffer holds the fed-back value.
- Saturation: delay=1, shift=1, inputs 0x7000 then 0x7000 → second output 0x7FFF. With 0x9000 then 0x9000 → 0x8000.
- Wrap and bypass, DEPTH_LOG2=4:
  - Stream 20 pairs with delay=3 → the read pointer wraps and echoes stay correct.
  - Switch to delay=0 → output equals input.
  - shift=0 → echo muted.
- Overrun: strobe, then a second strobe 2 cycles later → one valid pulse for the first pair only, `overrun_o`=1, outputs unaffected by the second pair.
- Reset mid-operation: assert `rst` in CALC → no `pktEchoValid_o`, outputs 0, CLEAR restarts, `wr_ptr`=0.
